ama_riscv_mul_pipe: RTL and testbench

// - 2-cycle pipelined integer multiplier spanning the EXE and MEM stages.
// - Produces its result at the WBK boundary. Supports M-ext MUL/MULH/MULHSU/MULHU,

---
 rtl/ama_riscv_mul_pipe_pkg.sv | 26 ++
 rtl/ama_riscv_mul_pipe_if.sv | 35 +++
 rtl/ama_riscv_mul_pp.sv | 33 +++
 rtl/ama_riscv_mul_pipe.sv | 89 ++++++++
 tb/tb_ama_riscv_mul_pipe.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ama_riscv_mul_pipe_pkg.sv
// Shared types for the pipelined multiplier: op encoding, register-file
// address type, partial-product bundle and the paired-destination helper.
package ama_riscv_mul_pipe_pkg;

  localparam int XLEN = 32;
  localparam int PP_W = 34;  // signed 17x17 product width

  typedef logic [4:0] rf_addr_t;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    MUL_P  = 3'd4
  } mul_op_t;

  // [0]=lo*lo, [1]=lo*hi, [2]=hi*lo, [3]=hi*hi (a-half first)
  typedef logic [3:0][PP_W-1:0] pp_t;

  // Paired destination of a widening op is always the odd register of the pair
  function automatic rf_addr_t get_rdp(rf_addr_t rd);
    return rd | 5'd1;
  endfunction

endpackage

// File: rtl/ama_riscv_mul_pipe_if.sv
// EXE-side request and MEM/WBK-side status/result bundle of the multiplier.
interface ama_riscv_mul_pipe_if;
  import ama_riscv_mul_pipe_pkg::*;

  logic             en;
  logic             flush_exe;
  logic             valid_exe;
  mul_op_t          mul_op_exe;
  logic [XLEN-1:0]  a_exe;
  logic [XLEN-1:0]  b_exe;
  rf_addr_t         rd_exe;

  logic             mult_inst_mem;
  rf_addr_t         rd_mem;
  logic             rd_we_mem;
  logic             rdp_we_mem;
  rf_addr_t         rd_wbk;
  logic             rd_we_wbk;
  logic             rdp_we_wbk;
  logic [XLEN-1:0]  res_wbk;
  logic [XLEN-1:0]  resp_wbk;

  modport master (
    output en, flush_exe, valid_exe, mul_op_exe, a_exe, b_exe, rd_exe,
    input  mult_inst_mem, rd_mem, rd_we_mem, rdp_we_mem,
           rd_wbk, rd_we_wbk, rdp_we_wbk, res_wbk, resp_wbk
  );

  modport slave (
    input  en, flush_exe, valid_exe, mul_op_exe, a_exe, b_exe, rd_exe,
    output mult_inst_mem, rd_mem, rd_we_mem, rdp_we_mem,
           rd_wbk, rd_we_wbk, rdp_we_wbk, res_wbk, resp_wbk
  );

endinterface

// File: rtl/ama_riscv_mul_pp.sv
// Combinational 33x33 partial-product generator. Each operand is extended
// to 33b per op signedness, then split into a signed 17b upper half and a
// zero-extended 16b lower half, giving four signed 17x17 products.
module ama_riscv_mul_pp
  import ama_riscv_mul_pipe_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  mul_op_t         op,
  output pp_t             pp
);

  logic                   sa, sb;
  logic signed [PP_W-1:0] al, ah, bl, bh;

  // rs1 is signed for everything but MULHU; rs2 only for MUL/MULH/MUL_P
  always_comb begin
    sa = (op != MULHU);
    sb = (op == MUL) || (op == MULH) || (op == MUL_P);
  end

  assign al = $signed({18'b0, a[15:0]});
  assign bl = $signed({18'b0, b[15:0]});
  assign ah = $signed({{18{sa & a[31]}}, a[31:16]});
  assign bh = $signed({{18{sb & b[31]}}, b[31:16]});

  // Every true product fits in 34 signed bits, so truncation is exact
  assign pp[0] = al * bl;
  assign pp[1] = al * bh;
  assign pp[2] = ah * bl;
  assign pp[3] = ah * bh;

endmodule

// File: rtl/ama_riscv_mul_pipe.sv
// 2-cycle pipelined multiplier spanning EXE->MEM->WBK. Partial products are
// registered into MEM, summed and selected into WBK. A mult in MEM is never
// forwarded, so only destination/we info is exposed from MEM.
module ama_riscv_mul_pipe
  import ama_riscv_mul_pipe_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  ama_riscv_mul_pipe_if.slave bus
);

  pp_t             pp_exe, pp_mem;
  logic            valid_mem;
  mul_op_t         op_mem;
  rf_addr_t        rd_mem_q;
  logic            rd_we_mem_c, rdp_we_mem_c;
  logic [63:0]     prod;

  rf_addr_t        rd_wbk_q;
  logic            rd_we_wbk_q, rdp_we_wbk_q;
  logic [XLEN-1:0] res_wbk_q, resp_wbk_q;

  ama_riscv_mul_pp u_pp (
    .a  (bus.a_exe),
    .b  (bus.b_exe),
    .op (bus.mul_op_exe),
    .pp (pp_exe)
  );

  // EXE->MEM stage register; flush kills the MEM valid even while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mem <= 1'b0;
      op_mem    <= MUL;
      rd_mem_q  <= '0;
      pp_mem    <= '0;
    end else begin
      if (bus.flush_exe)  valid_mem <= 1'b0;
      else if (bus.en)    valid_mem <= bus.valid_exe;
      if (bus.en) begin
        op_mem   <= bus.mul_op_exe;
        rd_mem_q <= bus.rd_exe;
        pp_mem   <= pp_exe;
      end
    end
  end

  // MEM-stage write enables; rdp only exists for an even, non-x0 rd
  always_comb begin
    rd_we_mem_c  = valid_mem && (rd_mem_q != '0);
    rdp_we_mem_c = rd_we_mem_c && (op_mem == MUL_P) && (get_rdp(rd_mem_q) != rd_mem_q);
  end

  // 66b sum of shifted partial products, kept modulo 2^64
  always_comb begin
    prod = 64'({pp_mem[3], 32'b0})
         + 64'({{16{pp_mem[2][PP_W-1]}}, pp_mem[2], 16'b0})
         + 64'({{16{pp_mem[1][PP_W-1]}}, pp_mem[1], 16'b0})
         + 64'({{32{pp_mem[0][PP_W-1]}}, pp_mem[0]});
  end

  // MEM->WBK stage register: result select and write-enable hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wbk_q     <= '0;
      rd_we_wbk_q  <= 1'b0;
      rdp_we_wbk_q <= 1'b0;
      res_wbk_q    <= '0;
      resp_wbk_q   <= '0;
    end else if (bus.en) begin
      rd_wbk_q     <= rd_mem_q;
      rd_we_wbk_q  <= rd_we_mem_c;
      rdp_we_wbk_q <= rdp_we_mem_c;
      res_wbk_q    <= ((op_mem == MUL) || (op_mem == MUL_P)) ? prod[31:0] : prod[63:32];
      resp_wbk_q   <= (op_mem == MUL_P) ? prod[63:32] : '0;
    end
  end

  assign bus.mult_inst_mem = valid_mem;
  assign bus.rd_mem        = rd_mem_q;
  assign bus.rd_we_mem     = rd_we_mem_c;
  assign bus.rdp_we_mem    = rdp_we_mem_c;
  assign bus.rd_wbk        = rd_wbk_q;
  assign bus.rd_we_wbk     = rd_we_wbk_q;
  assign bus.rdp_we_wbk    = rdp_we_wbk_q;
  assign bus.res_wbk       = res_wbk_q;
  assign bus.resp_wbk      = resp_wbk_q;

endmodule

// File: tb/tb_ama_riscv_mul_pipe.sv
// Bench for the pipelined multiplier: directed scenarios followed by a
// randomized stream checked against a 64b arithmetic reference model that
// tracks ops by pipeline-advance count.
module tb_ama_riscv_mul_pipe;
  import ama_riscv_mul_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ama_riscv_mul_pipe_if bus ();

  ama_riscv_mul_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    mul_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    rf_addr_t    rd;
  } rec_t;

  rec_t recs [0:1023];
  int   adv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic fl, input logic v, input mul_op_t op,
                       input logic [31:0] a, input logic [31:0] b, input rf_addr_t rd);
    bus.en = en; bus.flush_exe = fl; bus.valid_exe = v; bus.mul_op_exe = op;
    bus.a_exe = a; bus.b_exe = b; bus.rd_exe = rd;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, MUL, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 64b product by the op's signedness rules
  function automatic logic [63:0] ref_prod(input mul_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    case (op)
      MULHU:   begin x = {32'b0, a};          y = {32'b0, b};          end
      MULHSU:  begin x = {{32{a[31]}}, a};    y = {32'b0, b};          end
      default: begin x = {{32{a[31]}}, a};    y = {{32{b[31]}}, b};    end
    endcase
    return 64'(x * y);
  endfunction

  function automatic logic [31:0] ref_res(input rec_t r);
    logic [63:0] p;
    p = ref_prod(r.op, r.a, r.b);
    return (r.op == MUL || r.op == MUL_P) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] ref_resp(input rec_t r);
    logic [63:0] p;
    p = ref_prod(r.op, r.a, r.b);
    return (r.op == MUL_P) ? p[63:32] : 32'd0;
  endfunction

  function automatic rec_t get_rec(input int idx);
    rec_t r;
    r = '{1'b0, MUL, 32'd0, 32'd0, 5'd0};
    if (idx >= 0) r = recs[idx];
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rec_t m, w;
    logic r_en, r_fl, r_v;
    mul_op_t r_op;
    logic [31:0] r_a, r_b;
    rf_addr_t r_rd;

    idle();
    #12;
    chk("rst_mult_inst_mem", 64'(bus.mult_inst_mem), 0);
    chk("rst_rd_we_mem",     64'(bus.rd_we_mem), 0);
    chk("rst_rdp_we_mem",    64'(bus.rdp_we_mem), 0);
    chk("rst_rd_mem",        64'(bus.rd_mem), 0);
    chk("rst_rd_wbk",        64'(bus.rd_wbk), 0);
    chk("rst_rd_we_wbk",     64'(bus.rd_we_wbk), 0);
    chk("rst_rdp_we_wbk",    64'(bus.rdp_we_wbk), 0);
    chk("rst_res_wbk",       64'(bus.res_wbk), 0);
    chk("rst_resp_wbk",      64'(bus.resp_wbk), 0);
    #4 rst_n = 1'b1;
    tick();

    // MULHU max*max
    drive(1'b1, 1'b0, 1'b1, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
    tick(); idle();
    chk("mulhu_mem_valid", 64'(bus.mult_inst_mem), 1);
    chk("mulhu_rd_mem",    64'(bus.rd_mem), 5);
    chk("mulhu_rd_we_mem", 64'(bus.rd_we_mem), 1);
    tick();
    chk("mulhu_res",       64'(bus.res_wbk), 64'hFFFF_FFFE);
    chk("mulhu_rd_we_wbk", 64'(bus.rd_we_wbk), 1);
    chk("mulhu_rd_wbk",    64'(bus.rd_wbk), 5);

    // MULHSU then MULH back to back
    drive(1'b1, 1'b0, 1'b1, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    tick();
    drive(1'b1, 1'b0, 1'b1, MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    tick(); idle();
    chk("mulhsu_res",    64'(bus.res_wbk), 64'hFFFF_FFFF);
    chk("mulhsu_rd_wbk", 64'(bus.rd_wbk), 6);
    tick();
    chk("mulh_res",      64'(bus.res_wbk), 0);
    chk("mulh_rd_wbk",   64'(bus.rd_wbk), 7);
    chk("mulh_rd_we",    64'(bus.rd_we_wbk), 1);

    // MUL_P with even then odd rd
    drive(1'b1, 1'b0, 1'b1, MUL_P, 32'h8000_0000, 32'h8000_0000, 5'd10);
    tick();
    drive(1'b1, 1'b0, 1'b1, MUL_P, 32'h8000_0000, 32'h8000_0000, 5'd11);
    chk("mulp_even_rdp_we_mem", 64'(bus.rdp_we_mem), 1);
    tick(); idle();
    chk("mulp_odd_rdp_we_mem", 64'(bus.rdp_we_mem), 0);
    chk("mulp_even_res",       64'(bus.res_wbk), 0);
    chk("mulp_even_resp",      64'(bus.resp_wbk), 64'h4000_0000);
    chk("mulp_even_rdp_we",    64'(bus.rdp_we_wbk), 1);
    tick();
    chk("mulp_odd_rdp_we",     64'(bus.rdp_we_wbk), 0);
    chk("mulp_odd_rd_we",      64'(bus.rd_we_wbk), 1);
    chk("mulp_odd_rd_wbk",     64'(bus.rd_wbk), 11);
    chk("mulp_odd_resp",       64'(bus.resp_wbk), 64'h4000_0000);
    tick();

    // MUL 3*7 held in MEM by a 3-cycle stall
    drive(1'b1, 1'b0, 1'b1, MUL, 32'd3, 32'd7, 5'd7);
    tick();
    drive(1'b0, 1'b0, 1'b0, MUL, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_mem_valid", 64'(bus.mult_inst_mem), 1);
      chk("stall_rd_we_mem", 64'(bus.rd_we_mem), 1);
      chk("stall_rd_we_wbk", 64'(bus.rd_we_wbk), 0);
      chk("stall_res_wbk",   64'(bus.res_wbk), 0);
    end
    idle();
    tick();
    chk("stall_release_res",   64'(bus.res_wbk), 21);
    chk("stall_release_rd_we", 64'(bus.rd_we_wbk), 1);
    chk("stall_release_rd",    64'(bus.rd_wbk), 7);

    // Flush with en=1
    drive(1'b1, 1'b1, 1'b1, MUL, 32'd5, 32'd5, 5'd3);
    tick(); idle();
    chk("flush_mem_valid", 64'(bus.mult_inst_mem), 0);
    chk("flush_rd_we_mem", 64'(bus.rd_we_mem), 0);
    tick();
    chk("flush_rd_we_wbk", 64'(bus.rd_we_wbk), 0);

    // Flush with en=0
    drive(1'b0, 1'b1, 1'b1, MUL, 32'd5, 32'd5, 5'd3);
    tick(); idle();
    chk("flush_stall_mem_valid", 64'(bus.mult_inst_mem), 0);
    chk("flush_stall_rd_we_wbk", 64'(bus.rd_we_wbk), 0);
    tick();
    chk("flush_stall_rd_we_wbk2", 64'(bus.rd_we_wbk), 0);

    // rd = x0
    drive(1'b1, 1'b0, 1'b1, MUL, 32'd9, 32'd9, 5'd0);
    tick(); idle();
    chk("x0_mem_valid", 64'(bus.mult_inst_mem), 1);
    chk("x0_rd_we_mem", 64'(bus.rd_we_mem), 0);
    tick();
    chk("x0_rd_we_wbk", 64'(bus.rd_we_wbk), 0);

    // Async reset with ops in MEM and WBK
    drive(1'b1, 1'b0, 1'b1, MUL, 32'd2, 32'd3, 5'd1);
    tick();
    drive(1'b1, 1'b0, 1'b1, MUL_P, 32'd4, 32'd5, 5'd2);
    tick(); idle();
    chk("prerst_rd_we_mem",  64'(bus.rd_we_mem), 1);
    chk("prerst_rdp_we_mem", 64'(bus.rdp_we_mem), 1);
    chk("prerst_rd_we_wbk",  64'(bus.rd_we_wbk), 1);
    chk("prerst_res_wbk",    64'(bus.res_wbk), 6);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_valid",  64'(bus.mult_inst_mem), 0);
    chk("midrst_rd_we_mem",  64'(bus.rd_we_mem), 0);
    chk("midrst_rdp_we_mem", 64'(bus.rdp_we_mem), 0);
    chk("midrst_rd_we_wbk",  64'(bus.rd_we_wbk), 0);
    chk("midrst_rdp_we_wbk", 64'(bus.rdp_we_wbk), 0);
    chk("midrst_res_wbk",    64'(bus.res_wbk), 0);
    chk("midrst_rd_wbk",     64'(bus.rd_wbk), 0);
    #2 rst_n = 1'b1;

    // Randomized stream; recs[k] is the op accepted on the k-th advance
    adv = 0;
    for (int n = 0; n < 400; n++) begin
      r_en = ($urandom_range(0, 3) != 0);
      r_fl = ($urandom_range(0, 7) == 0);
      r_v  = ($urandom_range(0, 4) != 0);
      r_op = mul_op_t'(3'($urandom_range(0, 4)));
      r_a  = pick();
      r_b  = pick();
      r_rd = 5'($urandom_range(0, 31));
      drive(r_en, r_fl, r_v, r_op, r_a, r_b, r_rd);
      tick();
      if (r_en) begin
        recs[adv] = '{r_v && !r_fl, r_op, r_a, r_b, r_rd};
        adv++;
      end else if (r_fl && adv > 0) begin
        recs[adv-1].v = 1'b0;
      end
      m = get_rec(adv - 1);
      w = get_rec(adv - 2);
      chk("rnd_mem_valid",  64'(bus.mult_inst_mem), 64'(m.v));
      chk("rnd_rd_we_mem",  64'(bus.rd_we_mem),     64'(m.v && m.rd != 0));
      chk("rnd_rdp_we_mem", 64'(bus.rdp_we_mem),    64'(m.v && m.op == MUL_P && m.rd != 0 && !m.rd[0]));
      if (m.v) chk("rnd_rd_mem", 64'(bus.rd_mem), 64'(m.rd));
      chk("rnd_rd_we_wbk",  64'(bus.rd_we_wbk),     64'(w.v && w.rd != 0));
      chk("rnd_rdp_we_wbk", 64'(bus.rdp_we_wbk),    64'(w.v && w.op == MUL_P && w.rd != 0 && !w.rd[0]));
      if (w.v) begin
        chk("rnd_rd_wbk",   64'(bus.rd_wbk),   64'(w.rd));
        chk("rnd_res_wbk",  64'(bus.res_wbk),  64'(ref_res(w)));
        chk("rnd_resp_wbk", 64'(bus.resp_wbk), 64'(ref_resp(w)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
